// File: rtl/muldiv_pkg.sv
// Shared decode definitions for the RV32 M-extension path: opcodes, funct3
// operation encodings, and the iterative multiply/divide FSM states.
package muldiv_pkg;

  localparam logic [6:0] OPC_RTYPE     = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  // funct3[2] splits the divide group from the multiply group
  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 1 prep cycle, 32 shift-add or restoring
// shift-subtract cycles on a shared 64-bit register, 1 sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             mulEn,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state, nstate;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa, opb, bm;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             sgn_a, neg_res, div0, ovf;

  logic             is_div, a_neg, b_neg, qbit;
  logic [WIDTH:0]   add_a, add_b, sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, fix_val;

  assign is_div = op_is_div(op);
  assign a_neg  = opa[WIDTH-1] &
                  (op == F3_MULH || op == F3_MULHSU || op == F3_DIV || op == F3_REM);
  assign b_neg  = opb[WIDTH-1] & (op == F3_MULH || op == F3_DIV || op == F3_REM);

  // One 33-bit adder: adds multiplicand to the high word, or subtracts the
  // divisor from the shifted partial remainder (carry-in completes the negate).
  assign add_a = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign add_b = is_div ? ~{1'b0, bm} : {1'b0, bm};
  assign sum   = add_a + add_b + {{WIDTH{1'b0}}, is_div};
  // A set top bit means the shifted remainder already exceeds any 32-bit divisor
  assign qbit  = acc[2*WIDTH-1] | ~sum[WIDTH];

  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = sgn_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_val = prod[WIDTH-1:0];
    case (op)
      F3_MUL:                      fix_val = prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:             fix_val = div0 ? '1 : (ovf ? MOST_NEG : quo);
      F3_REM, F3_REMU:             fix_val = div0 ? opa : (ovf ? '0 : rem);
      default:                     fix_val = prod[WIDTH-1:0];
    endcase
  end

  always_comb begin
    nstate = state;
    stall  = 1'b0;
    done   = 1'b0;
    case (state)
      S_IDLE: begin
        stall = mulEn;
        if (mulEn) nstate = S_PREP;
      end
      S_PREP: begin
        stall  = 1'b1;
        nstate = S_RUN;
      end
      S_RUN: begin
        stall = 1'b1;
        if (cnt == LAST) nstate = S_FIX;
      end
      S_FIX: begin
        stall  = 1'b1;
        nstate = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        stall  = mulEn;
        nstate = mulEn ? S_PREP : S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      result  <= '0;
      op      <= '0;
      opa     <= '0;
      opb     <= '0;
      bm      <= '0;
      acc     <= '0;
      sgn_a   <= 1'b0;
      neg_res <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= nstate;
      case (state)
        S_IDLE, S_DONE: begin
          if (mulEn) begin
            op  <= funct3;
            opa <= rs1;
            opb <= rs2;
          end
        end
        S_PREP: begin
          bm      <= b_neg ? -opb : opb;
          acc     <= {{WIDTH{1'b0}}, (a_neg ? -opa : opa)};
          sgn_a   <= a_neg;
          neg_res <= a_neg ^ b_neg;
          div0    <= (opb == '0);
          ovf     <= (op == F3_DIV || op == F3_REM) && opa == MOST_NEG && opb == '1;
          cnt     <= '0;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div)
            acc <= {(qbit ? sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], qbit};
          else if (acc[0])
            acc <= {sum, acc[WIDTH-1:1]};
          else
            acc <= {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
        S_FIX: result <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + scoreboard bench for muldiv_unit: latency, stall window,
// signed/unsigned results, divide corner cases, reset abort, back-to-back.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        nreset, mulEn, stall, done;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, result;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] scb[$];

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .nreset(nreset), .mulEn(mulEn), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .stall(stall), .done(done), .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sbx, p;
    logic signed [31:0] as_, bs_, r;
    ua = {32'b0, a};  ub = {32'b0, b};
    sa = {{32{a[31]}}, a};  sbx = {{32{b[31]}}, b};
    as_ = a;  bs_ = b;
    case (f3)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sbx; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = as_ / bs_; return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = as_ % bs_; return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge of an IDLE/DONE cycle: raises the start request.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    mulEn = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    scb.push_back(exp);
    #1 chk("stall_at_start", {31'b0, stall}, 32'd1);
  endtask

  // Follows one operation from its start cycle through done, optionally
  // keeping mulEn high for 'hold' cycles or chaining a new start into DONE.
  task automatic track(input string tag, input int hold, input bit chain,
                       input logic [2:0] nf3, input logic [31:0] na, input logic [31:0] nb,
                       input logic [31:0] nexp);
    int st = 0, dn = 0;
    logic [31:0] exp;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clock);
      if (k > hold) mulEn = 1'b0;
      if (k == 1 || k <= hold) begin
        funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      end
      #1;
      if (k < 35) begin
        st += int'(stall);
        dn += int'(done);
      end
    end
    chk({tag, "_stall_window"}, 32'(st), 32'd34);
    chk({tag, "_early_done"}, 32'(dn), 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_stall_in_done"}, {31'b0, stall}, 32'd0);
    exp = (scb.size() > 0) ? scb.pop_front() : 32'hxxxx_xxxx;
    chk({tag, "_result"}, result, exp);
    if (chain) issue(nf3, na, nb, nexp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(negedge clock);
    issue(f3, a, b, exp);
    track(tag, 0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int dn = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock); #1;
      dn += int'(done);
    end
    chk(tag, 32'(dn), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    nreset = 1'b0; mulEn = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clock);
    nreset = 1'b1;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14);
    run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op("divu_z", 3'd5, 32'd13,         32'd0,         32'hFFFF_FFFF);
    run_op("remu_z", 3'd7, 32'd13,         32'd0,         32'd13);
    run_op("div_z",  3'd4, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF);
    run_op("rem_neg", 3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1);

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'(i);
      ra  = $urandom;
      rb  = (i == 5) ? 32'($urandom_range(1, 255)) : $urandom;
      run_op("rand", rf3, ra, rb, ref_op(rf3, ra, rb));
    end

    // Abort: reset lands 10 cycles into an operation
    run_op("pre_rst", 3'd0, 32'd3, 32'd5, 32'd15);
    @(negedge clock);
    issue(3'd0, 32'd9, 32'd9, 32'd81);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) mulEn = 1'b0;
      if (k == 10) nreset = 1'b0;
    end
    @(negedge clock); #1;
    chk("abort_result", result, 32'h0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    void'(scb.pop_back());
    nreset = 1'b1;
    count_done("abort_no_done", 40);
    run_op("post_rst", 3'd5, 32'd1000, 32'd10, 32'd100);

    // mulEn held for 20 cycles must run only one operation
    @(negedge clock);
    issue(3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    track("hold", 20, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    count_done("hold_single", 40);

    // Start sampled in DONE chains straight into the next operation
    @(negedge clock);
    issue(3'd0, 32'd6, 32'd7, 32'd42);
    track("b2b_first", 0, 1'b1, 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    track("b2b_second", 0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; only 32 is supported and verified.
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port nreset, input, 1, reset; synchronous and active-low.
REQ-004 The block SHALL have port mulEn, input, 1, start request from the decoder (R-type, funct7 = 1).
REQ-005 The block SHALL have port funct3, input, 3, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports rs1, rs2, input, 32 each, operand A and operand B from the register file.
REQ-007 The block SHALL have port stall, output, 1, freezes PC and register write while the operation is in flight.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, 32, value written back through writesel = 011.

Function
REQ-010 The FSM SHALL have states IDLE, PREP, RUN, FIX, DONE.
REQ-011 IDLE->PREP SHALL occur when mulEn=1 is sampled in IDLE or DONE; funct3, rs1 and rs2 are latched in that cycle.
REQ-012 PREP SHALL take 1 cycle: form magnitudes of the signed operands, record result sign, and detect divide-by-zero and overflow.
REQ-013 RUN SHALL take exactly 32 cycles: radix-2 shift-add (multiply) or restoring shift-subtract (divide), with a 5-bit iteration counter from 0 to 31.
REQ-014 FIX SHALL take 1 cycle: apply sign correction, then select the low or high product word, the quotient, or the remainder.
REQ-015 DONE SHALL take 1 cycle with done=1; it returns to IDLE, or goes to PREP if mulEn=1.
REQ-016 Latency: if start is sampled at cycle N, done SHALL be 1 at cycle N+35.
REQ-017 stall SHALL be 1 in PREP, RUN and FIX, and combinationally in any IDLE/DONE cycle with mulEn=1; otherwise 0.
REQ-018 mulEn SHALL be ignored in PREP, RUN and FIX; operand or funct3 changes there SHALL NOT affect the result.
REQ-019 result SHALL hold its last value until the next FIX completes.
REQ-020 Signedness: MULH is signed x signed, MULHSU is signed rs1 x unsigned rs2, MULHU, DIVU and REMU are unsigned; the full 64-bit product SHALL be formed internally.
REQ-021 Divide by zero: quotient SHALL be 0xFFFFFFFF (signed and unsigned), and remainder SHALL be rs1; the sequence length is unchanged.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient SHALL be 0x80000000 and remainder 0.
REQ-023 Remainder sign SHALL follow the dividend; quotient rounds toward zero.

Reset
REQ-024 With nreset=0 at a clock edge, the state SHALL be IDLE, counter 0, result 0x00000000, done 0, and stall 0 (mulEn permitting after release).
REQ-025 Reset mid-operation SHALL abort without a done pulse; the first post-reset start SHALL behave per REQ-016.

Structure
REQ-026 The funct3 operation encodings and the FSM state enum SHALL live in a shared package muldiv_pkg, alongside the existing opcode definitions.
REQ-027 The block SHALL be one module, with no sub-module; one shared 64-bit accumulator/remainder register and one 33-bit adder/subtractor serve both operations.

Verification
REQ-028 MUL, rs1=7, rs2=0xFFFFFFFD, start at N -> result 0xFFFFFFEB, done=1 at N+35, stall=1 for N..N+34.
REQ-029 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 13 / 0 -> 0xFFFFFFFF; REMU 13 / 0 -> 13.
REQ-032 Start at N, nreset=0 at N+10 -> IDLE, result 0, no done; mulEn re-asserted held through N+20 -> only one operation runs; a back-to-back start in DONE -> next done exactly 35 cycles later.
